// File: rtl/rv32_lsu_bus.sv
// Load/store unit bridging the RV32I MEM stage to NSLV memory-mapped slaves.
// One request in flight: region decode on addr[31:28], per-slave ack, timeout guard.
module rv32_lsu_bus #(
    parameter int unsigned NSLV    = 4,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic [1:0]         rsp_err,
    output logic [NSLV-1:0]    bus_sel,
    output logic [31:0]        bus_addr,
    output logic [31:0]        bus_wdata,
    output logic [3:0]         bus_wstrb,
    output logic               bus_we,
    output logic               bus_re,
    input  logic [NSLV-1:0]    bus_ack,
    input  logic [NSLV*32-1:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_DECODE  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        alo_q, alo_d;
    logic [NSLV-1:0]   sel_q, sel_d;
    logic [31:0]       baddr_q, baddr_d;
    logic [31:0]       bwdata_q, bwdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              bwe_q, bwe_d;
    logic              bre_q, bre_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rerr_q, rerr_d;

    logic              req_misalign, req_illegal, req_nodev;
    logic [3:0]        req_strb;
    logic              sel_ack;
    logic [31:0]       sel_rdata, lane, load_data;
    logic              release_bus;

    // Request classification, evaluated combinationally while IDLE.
    always_comb begin
        req_misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                       (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        req_illegal  = req_we ? (req_funct3 >= 3'd3)
                              : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
        req_nodev    = ({28'd0, req_addr[31:28]} >= NSLV);
        case (req_funct3[1:0])
            2'b00:   req_strb = 4'b0001 << req_addr[1:0];
            2'b01:   req_strb = req_addr[1] ? 4'b1100 : 4'b0011;
            default: req_strb = 4'b1111;
        endcase
    end

    always_comb begin
        sel_rdata = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (sel_q[i]) sel_rdata = bus_rdata[32*i +: 32];
        end
        sel_ack = |(bus_ack & sel_q);
        lane    = sel_rdata >> {alo_q, 3'b000};
        case (f3_q)
            3'd0:    load_data = {{24{lane[7]}}, lane[7:0]};
            3'd1:    load_data = {{16{lane[15]}}, lane[15:0]};
            3'd4:    load_data = {24'd0, lane[7:0]};
            3'd5:    load_data = {16'd0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        f3_d        = f3_q;
        alo_d       = alo_q;
        sel_d       = sel_q;
        baddr_d     = baddr_q;
        bwdata_d    = bwdata_q;
        wstrb_d     = wstrb_q;
        bwe_d       = bwe_q;
        bre_d       = bre_q;
        rvalid_d    = 1'b0;
        rdata_d     = '0;
        rerr_d      = ERR_OK;
        release_bus = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d  = req_we;
                    f3_d  = req_funct3;
                    alo_d = req_addr[1:0];
                    if (req_misalign || req_illegal) begin
                        state_d  = S_RESP;
                        rvalid_d = 1'b1;
                        rerr_d   = ERR_ALIGN;
                    end else if (req_nodev) begin
                        state_d  = S_RESP;
                        rvalid_d = 1'b1;
                        rerr_d   = ERR_DECODE;
                    end else begin
                        state_d  = S_ACCESS;
                        cnt_d    = '0;
                        sel_d    = NSLV'(1) << req_addr[31:28];
                        baddr_d  = {4'h0, req_addr[27:0]};
                        bwdata_d = req_wdata << {req_addr[1:0], 3'b000};
                        wstrb_d  = req_we ? req_strb : 4'b0000;
                        bwe_d    = req_we;
                        bre_d    = !req_we;
                    end
                end
            end
            S_ACCESS: begin
                // Ack wins over a timeout firing in the same cycle.
                if (sel_ack) begin
                    state_d     = S_RESP;
                    rvalid_d    = 1'b1;
                    rdata_d     = we_q ? '0 : load_data;
                    rerr_d      = ERR_OK;
                    release_bus = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = S_RESP;
                    rvalid_d    = 1'b1;
                    rerr_d      = ERR_TIMEOUT;
                    release_bus = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (release_bus) begin
            sel_d    = '0;
            baddr_d  = '0;
            bwdata_d = '0;
            wstrb_d  = '0;
            bwe_d    = 1'b0;
            bre_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            f3_q     <= '0;
            alo_q    <= '0;
            sel_q    <= '0;
            baddr_q  <= '0;
            bwdata_q <= '0;
            wstrb_q  <= '0;
            bwe_q    <= 1'b0;
            bre_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            alo_q    <= alo_d;
            sel_q    <= sel_d;
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
            wstrb_q  <= wstrb_d;
            bwe_q    <= bwe_d;
            bre_q    <= bre_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rvalid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rerr_q;
    assign bus_sel   = sel_q;
    assign bus_addr  = baddr_q;
    assign bus_wdata = bwdata_q;
    assign bus_wstrb = wstrb_q;
    assign bus_we    = bwe_q;
    assign bus_re    = bre_q;

endmodule
